// File: rtl/alu181_pkg.sv
// Shared definitions for the 74181 nibble sequencer: FSM states, config byte
// field positions and the ALU function-select codes the sequencer is used with.
package alu181_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CFG    = 3'd1,
    ST_LOAD_A = 3'd2,
    ST_LOAD_B = 3'd3,
    ST_EXEC   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // Config byte layout: {rsv[1:0], M, Cn_n, S[3:0]}
  localparam int CFG_S_LSB  = 0;
  localparam int CFG_CN_BIT = 4;
  localparam int CFG_M_BIT  = 5;

  localparam logic [3:0] S_ADD = 4'b1001;  // M=0: A plus B
  localparam logic [3:0] S_SUB = 4'b0110;  // M=0: A minus B minus 1 (plus carry-in)
  localparam logic [3:0] S_XOR = 4'b0110;  // M=1: A xor B

endpackage

// File: rtl/alu181_nibble_sequencer.sv
// Byte-stream front end that feeds a 74181 slice one nibble per cycle, ripples
// the carry through a register and presents the WIDTH-bit result on a valid/ready port.
module alu181_nibble_sequencer
  import alu181_pkg::*;
#(
  parameter int NIBBLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [7:0]           cmd_data,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic [3:0]           alu_s,
  output logic                 alu_m,
  output logic                 alu_cn_n,
  input  logic [3:0]           alu_f,
  input  logic                 alu_cn4_n,
  input  logic                 alu_aeqb,
  output logic [4*NIBBLES-1:0] res_data,
  output logic                 res_cout_n,
  output logic                 res_aeqb,
  output logic                 res_valid,
  input  logic                 res_ready
);

  localparam int WIDTH = 4 * NIBBLES;
  localparam int BYTES = NIBBLES / 2;

  state_t             state_reg, state_next;
  logic [5:0]         cfg_reg;
  logic [WIDTH-1:0]   a_reg, b_reg, res_data_reg;
  logic [1:0]         beat_reg, nib_reg;
  logic               carry_reg, aeqb_reg;

  logic accept, last_beat, last_nib, in_exec;

  assign cmd_ready = (state_reg == ST_CFG) || (state_reg == ST_LOAD_A) ||
                     (state_reg == ST_LOAD_B);
  assign accept    = cmd_valid & cmd_ready & ena;
  assign last_beat = (beat_reg == 2'(BYTES - 1));
  assign last_nib  = (nib_reg == 2'(NIBBLES - 1));
  assign in_exec   = (state_reg == ST_EXEC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (ena) begin
      case (state_reg)
        ST_IDLE:   state_next = ST_CFG;
        ST_CFG:    if (accept) state_next = ST_LOAD_A;
        ST_LOAD_A: if (accept && last_beat) state_next = ST_LOAD_B;
        ST_LOAD_B: if (accept && last_beat) state_next = ST_EXEC;
        ST_EXEC:   if (last_nib) state_next = ST_DONE;
        ST_DONE:   if (res_ready) state_next = ST_CFG;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_reg      <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      res_data_reg <= '0;
      beat_reg     <= '0;
      nib_reg      <= '0;
      carry_reg    <= 1'b1;
      aeqb_reg     <= 1'b0;
    end else if (ena) begin
      case (state_reg)
        ST_CFG: if (accept) cfg_reg <= cmd_data[5:0];
        ST_LOAD_A: if (accept) begin
          for (int j = 0; j < BYTES; j++)
            if (beat_reg == 2'(j)) a_reg[8*j +: 8] <= cmd_data;
          beat_reg <= last_beat ? 2'd0 : beat_reg + 2'd1;
        end
        ST_LOAD_B: if (accept) begin
          for (int j = 0; j < BYTES; j++)
            if (beat_reg == 2'(j)) b_reg[8*j +: 8] <= cmd_data;
          beat_reg <= last_beat ? 2'd0 : beat_reg + 2'd1;
          if (last_beat) begin
            nib_reg  <= '0;
            aeqb_reg <= 1'b1;
          end
        end
        ST_EXEC: begin
          for (int j = 0; j < NIBBLES; j++)
            if (nib_reg == 2'(j)) res_data_reg[4*j +: 4] <= alu_f;
          carry_reg <= alu_cn4_n;
          aeqb_reg  <= aeqb_reg & alu_aeqb;
          nib_reg   <= last_nib ? 2'd0 : nib_reg + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // ALU data and carry inputs are held quiet except while a nibble is in flight.
  always_comb begin
    alu_a    = 4'd0;
    alu_b    = 4'd0;
    alu_cn_n = 1'b1;
    if (in_exec) begin
      for (int j = 0; j < NIBBLES; j++) begin
        if (nib_reg == 2'(j)) begin
          alu_a = a_reg[4*j +: 4];
          alu_b = b_reg[4*j +: 4];
        end
      end
      alu_cn_n = (nib_reg == 2'd0) ? cfg_reg[CFG_CN_BIT] : carry_reg;
    end
  end

  assign alu_s      = cfg_reg[CFG_S_LSB +: 4];
  assign alu_m      = cfg_reg[CFG_M_BIT];
  assign res_data   = res_data_reg;
  assign res_cout_n = carry_reg;
  assign res_aeqb   = aeqb_reg;
  assign res_valid  = (state_reg == ST_DONE);

endmodule
